// File: rtl/irs_pkg.sv
// Shared constants and encodings for the IRS Wilkinson ramp servo.
package irs_pkg;

  localparam int unsigned DAC_W   = 12;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DB_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_LOAD,
    ST_WAIT,
    ST_SETTLE,
    ST_COMPARE,
    ST_LOAD
  } servo_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } servo_dir_t;

endpackage

// File: rtl/irs_wilkinson_servo_step.sv
// Signed count error against target, deadband test and coarse/fine step select.
module irs_wilkinson_servo_step
  import irs_pkg::*;
#(
  parameter int unsigned DAC_BITS    = DAC_W,
  parameter int unsigned COARSE_STEP = 16
) (
  input  logic [COUNT_W-1:0]  count,
  input  logic [COUNT_W-1:0]  target,
  input  logic [DB_W-1:0]     deadband,
  output servo_dir_t          direction,
  output logic [DAC_BITS-1:0] step,
  output logic                in_band
);

  localparam int unsigned ERR_W = COUNT_W + 1;

  logic [ERR_W-1:0] err;
  logic [ERR_W-1:0] mag;
  logic [ERR_W-1:0] db;
  logic [ERR_W-1:0] db8;

  // err is a 17-bit two's-complement value; mag is its magnitude
  always_comb begin
    err       = {1'b0, count} - {1'b0, target};
    mag       = err[ERR_W-1] ? ERR_W'(-err) : err;
    db        = ERR_W'(deadband);
    db8       = ERR_W'({deadband, 3'b000});
    in_band   = (mag <= db);
    direction = DIR_NONE;
    if (!in_band) begin
      direction = err[ERR_W-1] ? DIR_DOWN : DIR_UP;
    end
    step = (mag > db8) ? DAC_BITS'(COARSE_STEP) : DAC_BITS'(1);
  end

endmodule

// File: rtl/irs_wilkinson_servo.sv
// Closed-loop servo of the Wilkinson ramp DAC code against the TSTOUT clock count.
module irs_wilkinson_servo
  import irs_pkg::*;
#(
  parameter int unsigned          DAC_BITS    = DAC_W,
  parameter logic [DAC_BITS-1:0]  INIT_DAC    = DAC_BITS'(12'h800),
  parameter int unsigned          LOCK_COUNT  = 4,
  parameter int unsigned          COARSE_STEP = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [15:0]          count_i,
  input  logic                 update_i,
  input  logic [15:0]          target_i,
  input  logic [7:0]           deadband_i,
  output logic [DAC_BITS-1:0]  dac_o,
  output logic                 dac_load_o,
  input  logic                 dac_ack_i,
  output logic                 locked_o,
  output logic                 stalled_o
);

  localparam int unsigned         LOCK_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [DAC_BITS-1:0] DAC_MAX = {DAC_BITS{1'b1}};

  servo_state_t          state_q, state_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [DAC_BITS-1:0]   dac_d;
  logic                  load_d, locked_d, stalled_d;

  servo_dir_t            direction;
  logic [DAC_BITS-1:0]   step_amt;
  logic                  in_band;

  logic [DAC_BITS:0]     up_sum;
  logic [DAC_BITS-1:0]   dac_next;
  logic                  dac_moves;
  logic                  count_sat, count_zero, take_step;
  logic [LOCK_W-1:0]     lock_inc;

  irs_wilkinson_servo_step #(
    .DAC_BITS    (DAC_BITS),
    .COARSE_STEP (COARSE_STEP)
  ) u_step (
    .count     (count_q),
    .target    (target_i),
    .deadband  (deadband_i),
    .direction (direction),
    .step      (step_amt),
    .in_band   (in_band)
  );

  // Clamped candidate code; a step pinned at a rail leaves dac_moves low
  always_comb begin
    up_sum     = {1'b0, dac_o} + {1'b0, step_amt};
    dac_next   = dac_o;
    if (direction == DIR_UP) begin
      dac_next = up_sum[DAC_BITS] ? DAC_MAX : up_sum[DAC_BITS-1:0];
    end else if (direction == DIR_DOWN) begin
      dac_next = (dac_o < step_amt) ? '0 : dac_o - step_amt;
    end
    dac_moves  = (dac_next != dac_o);
    count_sat  = (count_q == '1);
    count_zero = (count_q == '0);
    take_step  = !count_sat && !count_zero && dac_moves;
    lock_inc   = (lock_cnt_q == LOCK_W'(LOCK_COUNT)) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable_i) state_d = ST_INIT_LOAD;
      ST_INIT_LOAD,
      ST_LOAD:      if (dac_ack_i) state_d = enable_i ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: begin
        if (!enable_i)     state_d = ST_IDLE;
        else if (update_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable_i)     state_d = ST_IDLE;
        else if (update_i) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (!enable_i)      state_d = ST_IDLE;
        else if (take_step) state_d = ST_LOAD;
        else                state_d = ST_WAIT;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the measurement/lock registers
  always_comb begin
    count_d    = count_q;
    lock_cnt_d = lock_cnt_q;
    dac_d      = dac_o;
    load_d     = dac_load_o;
    locked_d   = locked_o;
    stalled_d  = stalled_o;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) load_d = 1'b1;
      end
      ST_INIT_LOAD,
      ST_LOAD: begin
        if (dac_ack_i) load_d = 1'b0;
      end
      ST_SETTLE,
      ST_WAIT: begin
        if (!enable_i) begin
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else if (update_i && (state_q == ST_WAIT)) begin
          count_d = count_i;
        end
      end
      ST_COMPARE: begin
        if (!enable_i) begin
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else if (count_sat) begin
          stalled_d  = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else if (!count_zero) begin
          stalled_d = 1'b0;
          if (in_band) begin
            lock_cnt_d = lock_inc;
            locked_d   = (lock_inc == LOCK_W'(LOCK_COUNT));
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            dac_d      = dac_next;
            load_d     = dac_moves;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      lock_cnt_q <= '0;
      dac_o      <= INIT_DAC;
      dac_load_o <= 1'b0;
      locked_o   <= 1'b0;
      stalled_o  <= 1'b0;
    end else begin
      count_q    <= count_d;
      lock_cnt_q <= lock_cnt_d;
      dac_o      <= dac_d;
      dac_load_o <= load_d;
      locked_o   <= locked_d;
      stalled_o  <= stalled_d;
    end
  end

endmodule

// File: tb/tb_irs_wilkinson_servo.sv
// Directed scoreboard bench for irs_wilkinson_servo: DAC writes are checked against queued expectations.
module tb_irs_wilkinson_servo;

  logic        clk_i      = 1'b0;
  logic        rst_i      = 1'b1;
  logic        enable_i   = 1'b0;
  logic        update_i   = 1'b0;
  logic        dac_ack_i  = 1'b0;
  logic [15:0] count_i    = 16'd0;
  logic [15:0] target_i   = 16'd19968;
  logic [7:0]  deadband_i = 8'd4;
  logic [11:0] dac_o;
  logic        dac_load_o;
  logic        locked_o;
  logic        stalled_o;

  int          checks = 0;
  int          errors = 0;
  int          exp_dac;
  logic [11:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  irs_wilkinson_servo dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .count_i    (count_i),
    .update_i   (update_i),
    .target_i   (target_i),
    .deadband_i (deadband_i),
    .dac_o      (dac_o),
    .dac_load_o (dac_load_o),
    .dac_ack_i  (dac_ack_i),
    .locked_o   (locked_o),
    .stalled_o  (stalled_o)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every new DAC write request is matched against the oldest queued code
  always begin : load_monitor
    logic [11:0] e;
    @(posedge dac_load_o);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check("unexpected_load", 32'(dac_load_o), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("load_dac", 32'(dac_o), 32'(e));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic send_update(input logic [15:0] c);
    count_i  = c;
    update_i = 1'b1;
    tick(1);
    update_i = 1'b0;
  endtask

  task automatic do_ack();
    int n = 0;
    while (!dac_load_o && n < 20) begin
      tick(1);
      n++;
    end
    check("ack_wait", 32'(dac_load_o), 32'd1);
    dac_ack_i = 1'b1;
    tick(1);
    dac_ack_i = 1'b0;
    check("load_drop", 32'(dac_load_o), 32'd0);
  endtask

  // Correction expected: 2-cycle latency, ack, then the first update after it is discarded
  task automatic correct(input logic [15:0] c, input int exp);
    exp_q.push_back(12'(exp));
    send_update(c);
    check("lat_early", 32'(dac_load_o), 32'd0);
    tick(1);
    check("lat_2cyc", 32'(dac_load_o), 32'd1);
    do_ack();
    send_update(c);
    tick(2);
    check("settle_discard", 32'(dac_load_o), 32'd0);
    check("dac_after", 32'(dac_o), 32'(exp));
  endtask

  task automatic hold(input logic [15:0] c, input int exp);
    send_update(c);
    tick(2);
    check("hold_no_load", 32'(dac_load_o), 32'd0);
    check("hold_dac", 32'(dac_o), 32'(exp));
  endtask

  initial begin
    tick(3);
    check("rst_dac", 32'(dac_o), 32'h800);
    check("rst_load", 32'(dac_load_o), 32'd0);
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_stalled", 32'(stalled_o), 32'd0);

    enable_i = 1'b1;
    exp_q.push_back(12'h800);
    rst_i = 1'b0;
    tick(1);
    check("first_load_1cyc", 32'(dac_load_o), 32'd1);
    do_ack();
    exp_dac = 32'h800;
    send_update(16'd20100);
    tick(2);
    check("init_settle_discard", 32'(dac_load_o), 32'd0);

    // Coarse correction: err=132 > 8*4
    exp_dac += 16;
    correct(16'd20100, exp_dac);

    for (int i = 0; i < 4; i++) begin
      send_update(16'd19970);
      tick(1);
      check("lock_progress", 32'(locked_o), 32'(i == 3));
      check("lock_no_load", 32'(dac_load_o), 32'd0);
    end

    // err=32 is fine step, err=33 is coarse, err=-8 fine down
    exp_dac += 1;
    correct(16'd20000, exp_dac);
    check("unlock_on_step", 32'(locked_o), 32'd0);
    exp_dac += 16;
    correct(16'd20001, exp_dac);
    exp_dac -= 1;
    correct(16'd19960, exp_dac);
    hold(16'd19972, exp_dac);
    hold(16'd19964, exp_dac);
    check("band_edges_locking", 32'(locked_o), 32'd0);
    hold(16'd19968, exp_dac);
    hold(16'd19968, exp_dac);
    check("relock", 32'(locked_o), 32'd1);

    send_update(16'hFFFF);
    tick(1);
    check("stall_set", 32'(stalled_o), 32'd1);
    check("stall_unlock", 32'(locked_o), 32'd0);
    check("stall_dac", 32'(dac_o), 32'(exp_dac));
    hold(16'd19968, exp_dac);
    check("stall_clear", 32'(stalled_o), 32'd0);
    hold(16'd0, exp_dac);
    check("zero_ignored_lock", 32'(locked_o), 32'd0);

    while (exp_dac < 4095) begin
      exp_dac = (exp_dac + 16 > 4095) ? 4095 : exp_dac + 16;
      correct(16'd20100, exp_dac);
    end
    hold(16'd20100, 4095);
    while (exp_dac > 0) begin
      exp_dac = (exp_dac < 16) ? 0 : exp_dac - 16;
      correct(16'd1, exp_dac);
    end
    hold(16'd1, 0);

    // Drop enable mid-handshake: request held until ack, then idle
    exp_q.push_back(12'd16);
    send_update(16'd20100);
    tick(1);
    check("dis_load_up", 32'(dac_load_o), 32'd1);
    enable_i = 1'b0;
    tick(3);
    check("dis_load_held", 32'(dac_load_o), 32'd1);
    check("dis_dac_held", 32'(dac_o), 32'd16);
    do_ack();
    tick(1);
    check("dis_idle_no_load", 32'(dac_load_o), 32'd0);
    enable_i = 1'b1;
    exp_q.push_back(12'd16);
    tick(1);
    check("reenable_1cyc", 32'(dac_load_o), 32'd1);
    do_ack();
    send_update(16'd20100);
    tick(1);

    // Async reset in the middle of a LOAD, between clock edges
    exp_q.push_back(12'd32);
    send_update(16'd20100);
    tick(1);
    check("pre_rst_load", 32'(dac_load_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("async_rst_load", 32'(dac_load_o), 32'd0);
    check("async_rst_dac", 32'(dac_o), 32'h800);
    exp_q.push_back(12'h800);
    #1 rst_i = 1'b0;
    tick(1);
    check("post_rst_load", 32'(dac_load_o), 32'd1);
    do_ack();
    tick(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
